// File: rtl/pa_lsu_vb_wb_ctrl_if.sv
// ---------------------------------------------------------------------------
// pa_lsu_vb_wb_ctrl_if
//
// Victim-buffer write-back bus between the LSU write-back controller (master)
// and the BIU (slave).
//
// Handshake semantics:
//   lsu_biu_vb_req is held with lsu_biu_vb_addr until biu_lsu_vb_grant is
//   seen high on a clock edge; lsu_biu_vb_wvld is held with the current
//   lsu_biu_vb_wdata/lsu_biu_vb_wlast until biu_lsu_vb_wready is seen high on
//   a clock edge (valid never drops while waiting, no bubbles between beats);
//   biu_lsu_vb_cmplt is a single-cycle write response, and inputs that arrive
//   outside the phase that expects them are ignored.
//
// Signals:
//   lsu_biu_vb_req    master->slave  address request
//   lsu_biu_vb_addr   master->slave  32-bit line-aligned burst address
//   biu_lsu_vb_grant  slave->master  address accepted
//   lsu_biu_vb_wvld   master->slave  write beat valid
//   lsu_biu_vb_wdata  master->slave  64-bit write beat
//   lsu_biu_vb_wlast  master->slave  final beat marker
//   biu_lsu_vb_wready slave->master  beat accepted
//   biu_lsu_vb_cmplt  slave->master  write response
//   biu_lsu_vb_err    slave->master  error status with the response
//                                    (only when PA_LSU_VB_WB_ERR_EN is defined)
// ---------------------------------------------------------------------------
interface pa_lsu_vb_wb_ctrl_if;
  logic        lsu_biu_vb_req;
  logic [31:0] lsu_biu_vb_addr;
  logic        biu_lsu_vb_grant;
  logic        lsu_biu_vb_wvld;
  logic [63:0] lsu_biu_vb_wdata;
  logic        lsu_biu_vb_wlast;
  logic        biu_lsu_vb_wready;
  logic        biu_lsu_vb_cmplt;
`ifdef PA_LSU_VB_WB_ERR_EN
  logic        biu_lsu_vb_err;

  modport master (
    output lsu_biu_vb_req, lsu_biu_vb_addr, lsu_biu_vb_wvld,
           lsu_biu_vb_wdata, lsu_biu_vb_wlast,
    input  biu_lsu_vb_grant, biu_lsu_vb_wready, biu_lsu_vb_cmplt,
           biu_lsu_vb_err
  );

  modport slave (
    input  lsu_biu_vb_req, lsu_biu_vb_addr, lsu_biu_vb_wvld,
           lsu_biu_vb_wdata, lsu_biu_vb_wlast,
    output biu_lsu_vb_grant, biu_lsu_vb_wready, biu_lsu_vb_cmplt,
           biu_lsu_vb_err
  );
`else
  modport master (
    output lsu_biu_vb_req, lsu_biu_vb_addr, lsu_biu_vb_wvld,
           lsu_biu_vb_wdata, lsu_biu_vb_wlast,
    input  biu_lsu_vb_grant, biu_lsu_vb_wready, biu_lsu_vb_cmplt
  );

  modport slave (
    input  lsu_biu_vb_req, lsu_biu_vb_addr, lsu_biu_vb_wvld,
           lsu_biu_vb_wdata, lsu_biu_vb_wlast,
    output biu_lsu_vb_grant, biu_lsu_vb_wready, biu_lsu_vb_cmplt
  );
`endif
endinterface

// File: rtl/pa_lsu_vb_wb_ctrl.sv
// ---------------------------------------------------------------------------
// pa_lsu_vb_wb_ctrl
//
// Victim-buffer write-back controller. Picks one requesting VB entry
// round-robin, snapshots its line address and 256-bit dirty data, writes the
// line to the BIU as a 4-beat 64-bit burst, and pulses a completion back to
// that entry when the bus write response arrives.
//
// Optional feature macro: PA_LSU_VB_WB_ERR_EN
//   defined   : bus error status is sampled with the write response and
//               accumulated in vb_wb_err_sticky (cleared only by reset);
//               the completion pulse is still issued on an error.
//   undefined : no error input/output; bus error status is discarded.
//
// Ports:
//   forever_cpuclk         clock
//   cpurst                 asynchronous active-high reset
//   rtu_yy_xx_async_flush  pipeline flush
//   vb_entry_biu_req       per-entry write-back request
//   vb_entry_addr          per-entry line address [31:5], entry i at [27i+:27]
//   vb_entry_data          per-entry line data, entry i at [256i+:256]
//   vb_wb_grant            one-hot grant pulse (combinational, IDLE cycle)
//   vb_wb_cmplt            one-hot completion pulse (combinational, RESP cycle)
//   biu                    BIU write-back bus (master side)
//   vb_wb_err_sticky       sticky bus error flag (PA_LSU_VB_WB_ERR_EN only)
//   vb_wb_dbginfo          current FSM state
// ---------------------------------------------------------------------------
module pa_lsu_vb_wb_ctrl #(
  parameter int ENTRY_NUM = 2
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst,
  input  logic                     rtu_yy_xx_async_flush,
  input  logic [ENTRY_NUM-1:0]     vb_entry_biu_req,
  input  logic [27*ENTRY_NUM-1:0]  vb_entry_addr,
  input  logic [256*ENTRY_NUM-1:0] vb_entry_data,
  output logic [ENTRY_NUM-1:0]     vb_wb_grant,
  output logic [ENTRY_NUM-1:0]     vb_wb_cmplt,
  pa_lsu_vb_wb_ctrl_if.master      biu,
`ifdef PA_LSU_VB_WB_ERR_EN
  output logic                     vb_wb_err_sticky,
`endif
  output logic [1:0]               vb_wb_dbginfo
);

  localparam int IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b01;
  localparam logic [1:0] DATA = 2'b10;
  localparam logic [1:0] RESP = 2'b11;

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       beat_q;
  logic             kill_q;
  logic [26:0]      addr_q;
  logic [255:0]     data_q;

  logic             arb_vld;
  logic [IDX_W-1:0] arb_sel;
  int               cand;
  logic             grant_fire;
  logic             resp_fire;
  logic [IDX_W-1:0] rr_next;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    arb_vld = 1'b0;
    arb_sel = '0;
    cand    = 0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= ENTRY_NUM) cand = cand - ENTRY_NUM;
      if (!arb_vld && vb_entry_biu_req[cand]) begin
        arb_vld = 1'b1;
        arb_sel = IDX_W'(cand);
      end
    end
  end

  assign rr_next = (arb_sel == IDX_W'(ENTRY_NUM - 1)) ? '0 : arb_sel + 1'b1;

  // cpurst gates the grant so every output is low while reset is held,
  // even if entries keep requesting.
  assign grant_fire = (state == IDLE) && arb_vld && !rtu_yy_xx_async_flush && !cpurst;
  assign resp_fire  = (state == RESP) && biu.biu_lsu_vb_cmplt;

  assign vb_wb_grant = grant_fire ? (ENTRY_NUM'(1) << arb_sel) : '0;

  // A flush landing in the response cycle has already reset the entry, so it
  // suppresses the pulse just like a flush seen earlier in the burst.
  assign vb_wb_cmplt = (resp_fire && !kill_q && !rtu_yy_xx_async_flush)
                       ? (ENTRY_NUM'(1) << idx_q) : '0;

  assign biu.lsu_biu_vb_req   = (state == REQ);
  assign biu.lsu_biu_vb_addr  = {addr_q, 5'b0};
  assign biu.lsu_biu_vb_wvld  = (state == DATA);
  assign biu.lsu_biu_vb_wdata = data_q[64*beat_q +: 64];
  assign biu.lsu_biu_vb_wlast = (state == DATA) && (beat_q == 2'd3);

  assign vb_wb_dbginfo = state;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      idx_q  <= '0;
      beat_q <= 2'd0;
      kill_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Entry request is not looked at again after this cycle.
          if (grant_fire) begin
            state  <= REQ;
            idx_q  <= arb_sel;
            addr_q <= vb_entry_addr[27*arb_sel +: 27];
            data_q <= vb_entry_data[256*arb_sel +: 256];
            rr_ptr <= rr_next;
          end
        end
        REQ: begin
          // Once the bus has the address the burst must finish; a coincident
          // flush only marks the transaction as killed.
          if (biu.biu_lsu_vb_grant) begin
            state  <= DATA;
            beat_q <= 2'd0;
            if (rtu_yy_xx_async_flush) kill_q <= 1'b1;
          end else if (rtu_yy_xx_async_flush) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (rtu_yy_xx_async_flush) kill_q <= 1'b1;
          if (biu.biu_lsu_vb_wready) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) state <= RESP;
          end
        end
        RESP: begin
          if (biu.biu_lsu_vb_cmplt) begin
            state  <= IDLE;
            kill_q <= 1'b0;
          end else if (rtu_yy_xx_async_flush) begin
            kill_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PA_LSU_VB_WB_ERR_EN
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      vb_wb_err_sticky <= 1'b0;
    end else if (resp_fire && biu.biu_lsu_vb_err) begin
      vb_wb_err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pa_lsu_vb_wb_ctrl.sv
module tb_pa_lsu_vb_wb_ctrl;
  localparam int N = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              flush = 1'b0;
  logic [N-1:0]      req   = '0;
  logic [27*N-1:0]   eaddr = '0;
  logic [256*N-1:0]  edata = '0;
  logic [N-1:0]      grant;
  logic [N-1:0]      cmplt;
  logic [1:0]        dbg;
`ifdef PA_LSU_VB_WB_ERR_EN
  logic              sticky;
`endif

  pa_lsu_vb_wb_ctrl_if bus();

  pa_lsu_vb_wb_ctrl #(.ENTRY_NUM(N)) dut (
    .forever_cpuclk        (clk),
    .cpurst                (rst),
    .rtu_yy_xx_async_flush (flush),
    .vb_entry_biu_req      (req),
    .vb_entry_addr         (eaddr),
    .vb_entry_data         (edata),
    .vb_wb_grant           (grant),
    .vb_wb_cmplt           (cmplt),
    .biu                   (bus),
`ifdef PA_LSU_VB_WB_ERR_EN
    .vb_wb_err_sticky      (sticky),
`endif
    .vb_wb_dbginfo         (dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.biu_lsu_vb_grant  = 1'b0;
    bus.biu_lsu_vb_wready = 1'b0;
    bus.biu_lsu_vb_cmplt  = 1'b0;
`ifdef PA_LSU_VB_WB_ERR_EN
    bus.biu_lsu_vb_err    = 1'b0;
`endif
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Transaction-level view: arbitration with a round-robin pointer, an
  // expected-beat queue filled at grant time, and a kill flag.
  bit          model_en = 1'b0;
  int          m_phase, m_ptr, m_idx;
  bit          m_kill, m_sticky;
  logic [31:0] m_addr;
  logic [63:0] exp_q[$];
  int          glog[$];
  int          beats_sent, cmplt_cnt, data_cycles;

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_idx = 0; m_kill = 0; m_sticky = 0;
    m_addr = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int cur, sel;
    logic [N-1:0] eg, ec;
    cur = m_phase; sel = -1; eg = '0; ec = '0;
    chk("state", 64'(dbg), 64'(cur));
`ifdef PA_LSU_VB_WB_ERR_EN
    chk("sticky", 64'(sticky), 64'(m_sticky));
`endif
    case (cur)
      0: begin
        if (!flush)
          for (int i = 0; i < N; i++)
            if (sel < 0 && req[(m_ptr + i) % N]) sel = (m_ptr + i) % N;
        if (sel >= 0) begin
          eg[sel] = 1'b1;
          m_idx   = sel;
          m_ptr   = (sel + 1) % N;
          m_addr  = {eaddr[27*sel +: 27], 5'b0};
          exp_q.delete();
          for (int k = 0; k < 4; k++) exp_q.push_back(edata[256*sel + 64*k +: 64]);
          glog.push_back(sel);
          m_phase = 1;
        end
      end
      1: begin
        chk("addr", 64'(bus.lsu_biu_vb_addr), 64'(m_addr));
        if (bus.biu_lsu_vb_grant) begin
          m_phase = 2;
          if (flush) m_kill = 1;
        end else if (flush) begin
          m_phase = 0;
        end
      end
      2: begin
        if (exp_q.size() > 0) begin
          chk("wdata", bus.lsu_biu_vb_wdata, exp_q[0]);
          chk("wlast", 64'(bus.lsu_biu_vb_wlast), 64'(exp_q.size() == 1));
        end else begin
          errors++;
          $display("FAIL beat_q: burst beyond 4 beats (t=%0t)", $time);
        end
        if (flush) m_kill = 1;
        if (bus.biu_lsu_vb_wready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_phase = 3;
        end
      end
      default: begin
        if (bus.biu_lsu_vb_cmplt) begin
          if (!(m_kill || flush)) ec[m_idx] = 1'b1;
`ifdef PA_LSU_VB_WB_ERR_EN
          if (bus.biu_lsu_vb_err) m_sticky = 1;
`endif
          m_phase = 0;
          m_kill  = 0;
        end else if (flush) begin
          m_kill = 1;
        end
      end
    endcase
    chk("grant", 64'(grant), 64'(eg));
    chk("cmplt", 64'(cmplt), 64'(ec));
    chk("breq",  64'(bus.lsu_biu_vb_req),  64'(cur == 1));
    chk("wvld",  64'(bus.lsu_biu_vb_wvld), 64'(cur == 2));
    if (cur != 2) chk("wlast_idle", 64'(bus.lsu_biu_vb_wlast), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (model_en) model_step();
      if (bus.lsu_biu_vb_wvld && bus.biu_lsu_vb_wready) beats_sent++;
      if (cmplt != '0) cmplt_cnt++;
      if (dbg == 2'b10) data_cycles++;
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [N-1:0] req;
    logic         fl, bg, wr, bc;
    logic [1:0]   st;
    logic [N-1:0] gnt;
    logic         breq, wvld, wlast;
    logic [63:0]  wdata;
    logic [N-1:0] cmp;
    logic [31:0]  addr;
  } vec_t;

  vec_t vt[$];

  function automatic void add(logic [N-1:0] r, logic fl, logic bg, logic wr, logic bc,
                              logic [1:0] st, logic [N-1:0] g, logic brq, logic wv,
                              logic wl, logic [63:0] wd, logic [N-1:0] cm, logic [31:0] ad);
    vec_t v;
    v.req = r; v.fl = fl; v.bg = bg; v.wr = wr; v.bc = bc;
    v.st = st; v.gnt = g; v.breq = brq; v.wvld = wv; v.wlast = wl;
    v.wdata = wd; v.cmp = cm; v.addr = ad;
    vt.push_back(v);
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; flush = 1'b0; bus_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Wait (bounded) for the FSM to reach a given state.
  task automatic wait_state(input logic [1:0] s, input string name);
    for (int t = 0; t < 50 && dbg != s; t++) step();
    chk(name, 64'(dbg), 64'(s));
  endtask

  task automatic serve_one();
    wait_state(2'b01, "wait_req");
    bus.biu_lsu_vb_grant = 1'b1; step();
    bus.biu_lsu_vb_grant = 1'b0;
    bus.biu_lsu_vb_wready = 1'b1;
    wait_state(2'b11, "wait_resp");
    bus.biu_lsu_vb_wready = 1'b0;
    bus.biu_lsu_vb_cmplt = 1'b1; step();
    bus.biu_lsu_vb_cmplt = 1'b0;
  endtask

  localparam logic [31:0] A0 = 32'h002468A0;  // {27'h12345, 5'b0}
  localparam logic [31:0] A1 = 32'h00015780;  // {27'h00ABC, 5'b0}

  initial begin
    int base;
    bus_idle();

    // ---- reset state ----
    @(negedge clk);
    chk("rst_state", 64'(dbg), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_breq",  64'(bus.lsu_biu_vb_req), 64'd0);
    chk("rst_wvld",  64'(bus.lsu_biu_vb_wvld), 64'd0);
    chk("rst_addr",  64'(bus.lsu_biu_vb_addr), 64'd0);
    chk("rst_wdata", bus.lsu_biu_vb_wdata, 64'd0);

    // ---- table: basic burst, flush in REQ, flush with grant, stray inputs ----
    eaddr[0 +: 27]  = 27'h12345;
    eaddr[27 +: 27] = 27'h00ABC;
    for (int k = 0; k < 4; k++) begin
      edata[64*k +: 64]       = 64'(k);
      edata[256 + 64*k +: 64] = 64'(16 + k);
    end
    add(2'b01,0,0,0,0, 2'd0,2'b01,0,0,0, 64'h0,2'b00, A0);
    add(2'b00,0,0,0,0, 2'd1,2'b00,1,0,0, 64'h0,2'b00, A0);
    add(2'b00,0,1,0,0, 2'd1,2'b00,1,0,0, 64'h0,2'b00, A0);
    add(2'b00,0,0,0,0, 2'd2,2'b00,0,1,0, 64'h0,2'b00, A0);
    add(2'b00,0,0,1,0, 2'd2,2'b00,0,1,0, 64'h0,2'b00, A0);
    add(2'b00,0,0,1,0, 2'd2,2'b00,0,1,0, 64'h1,2'b00, A0);
    add(2'b00,0,0,1,0, 2'd2,2'b00,0,1,0, 64'h2,2'b00, A0);
    add(2'b00,0,0,1,0, 2'd2,2'b00,0,1,1, 64'h3,2'b00, A0);
    add(2'b00,0,0,0,0, 2'd3,2'b00,0,0,0, 64'h0,2'b00, A0);
    add(2'b00,0,0,0,1, 2'd3,2'b00,0,0,0, 64'h0,2'b01, A0);
    add(2'b11,0,0,0,0, 2'd0,2'b10,0,0,0, 64'h0,2'b00, A0);
    add(2'b00,1,0,0,0, 2'd1,2'b00,1,0,0, 64'h0,2'b00, A1);
    add(2'b01,0,0,0,0, 2'd0,2'b01,0,0,0, 64'h0,2'b00, A1);
    add(2'b00,1,1,0,0, 2'd1,2'b00,1,0,0, 64'h0,2'b00, A0);
    add(2'b00,0,0,1,0, 2'd2,2'b00,0,1,0, 64'h0,2'b00, A0);
    add(2'b00,0,0,1,0, 2'd2,2'b00,0,1,0, 64'h1,2'b00, A0);
    add(2'b00,0,0,1,0, 2'd2,2'b00,0,1,0, 64'h2,2'b00, A0);
    add(2'b00,0,0,1,0, 2'd2,2'b00,0,1,1, 64'h3,2'b00, A0);
    add(2'b00,0,0,0,1, 2'd3,2'b00,0,0,0, 64'h0,2'b00, A0);
    add(2'b10,1,0,0,0, 2'd0,2'b00,0,0,0, 64'h0,2'b00, A0);
    add(2'b10,0,0,0,0, 2'd0,2'b10,0,0,0, 64'h0,2'b00, A0);
    add(2'b00,0,0,1,1, 2'd1,2'b00,1,0,0, 64'h0,2'b00, A1);
    add(2'b00,0,1,0,0, 2'd1,2'b00,1,0,0, 64'h0,2'b00, A1);
    add(2'b00,0,0,0,0, 2'd2,2'b00,0,1,0, 64'h10,2'b00, A1);
    add(2'b00,0,0,1,0, 2'd2,2'b00,0,1,0, 64'h10,2'b00, A1);

    step();
    rst = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      req = vt[i].req; flush = vt[i].fl;
      bus.biu_lsu_vb_grant  = vt[i].bg;
      bus.biu_lsu_vb_wready = vt[i].wr;
      bus.biu_lsu_vb_cmplt  = vt[i].bc;
      @(negedge clk);
      chk($sformatf("v%0d_state", i), 64'(dbg), 64'(vt[i].st));
      chk($sformatf("v%0d_grant", i), 64'(grant), 64'(vt[i].gnt));
      chk($sformatf("v%0d_breq", i),  64'(bus.lsu_biu_vb_req), 64'(vt[i].breq));
      chk($sformatf("v%0d_wvld", i),  64'(bus.lsu_biu_vb_wvld), 64'(vt[i].wvld));
      chk($sformatf("v%0d_wlast", i), 64'(bus.lsu_biu_vb_wlast), 64'(vt[i].wlast));
      chk($sformatf("v%0d_cmplt", i), 64'(cmplt), 64'(vt[i].cmp));
      if (vt[i].wvld) chk($sformatf("v%0d_wdata", i), bus.lsu_biu_vb_wdata, vt[i].wdata);
      if (vt[i].breq) chk($sformatf("v%0d_addr", i), 64'(bus.lsu_biu_vb_addr), 64'(vt[i].addr));
      step();
    end

    // ---- hand sequences, checked by the model as well ----
    do_reset();
    model_en = 1'b1;

    // wready stall of 2 cycles on beat 1: 6 cycles in DATA
    base = cmplt_cnt;
    req = 2'b01; step();
    req = 2'b00; bus.biu_lsu_vb_grant = 1'b1; step();
    bus.biu_lsu_vb_grant = 1'b0; data_cycles = 0;
    bus.biu_lsu_vb_wready = 1'b1; step();
    bus.biu_lsu_vb_wready = 1'b0; step(); step();
    bus.biu_lsu_vb_wready = 1'b1; step(); step(); step();
    bus.biu_lsu_vb_wready = 1'b0; bus.biu_lsu_vb_cmplt = 1'b1; step();
    bus.biu_lsu_vb_cmplt = 1'b0;
    chk("stall_data_cycles", 64'(data_cycles), 64'd6);
    chk("stall_cmplt_cnt", 64'(cmplt_cnt - base), 64'd1);

    // flush during beat 2: burst finishes, no completion pulse
    base = cmplt_cnt; beats_sent = 0;
    req = 2'b10; step();
    req = 2'b00; bus.biu_lsu_vb_grant = 1'b1; step();
    bus.biu_lsu_vb_grant = 1'b0; bus.biu_lsu_vb_wready = 1'b1; step(); step();
    flush = 1'b1; step();
    flush = 1'b0; step();
    bus.biu_lsu_vb_wready = 1'b0; bus.biu_lsu_vb_cmplt = 1'b1; step();
    bus.biu_lsu_vb_cmplt = 1'b0;
    chk("flush_beats", 64'(beats_sent), 64'd4);
    chk("flush_cmplt_cnt", 64'(cmplt_cnt - base), 64'd0);
    chk("flush_back_idle", 64'(dbg), 64'd0);

    // continuous requests: round-robin order 0,1,0
    glog.delete();
    req = 2'b11;
    for (int t = 0; t < 3; t++) serve_one();
    chk("rr_count", 64'(glog.size() >= 3), 64'd1);
    if (glog.size() >= 3) begin
      chk("rr_0", 64'(glog[0]), 64'd0);
      chk("rr_1", 64'(glog[1]), 64'd1);
      chk("rr_2", 64'(glog[2]), 64'd0);
    end

    // async reset in DATA: outputs drop immediately, pointer back to 0
    wait_state(2'b01, "wait_req_rst");
    bus.biu_lsu_vb_grant = 1'b1; step();
    bus.biu_lsu_vb_grant = 1'b0;
    chk("pre_rst_wvld", 64'(bus.lsu_biu_vb_wvld), 64'd1);
    model_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 64'(dbg), 64'd0);
    chk("arst_grant", 64'(grant), 64'd0);
    chk("arst_wvld",  64'(bus.lsu_biu_vb_wvld), 64'd0);
    chk("arst_wlast", 64'(bus.lsu_biu_vb_wlast), 64'd0);
    chk("arst_wdata", bus.lsu_biu_vb_wdata, 64'd0);
    chk("arst_breq",  64'(bus.lsu_biu_vb_req), 64'd0);
    chk("arst_addr",  64'(bus.lsu_biu_vb_addr), 64'd0);
    chk("arst_cmplt", 64'(cmplt), 64'd0);
    step();
    rst = 1'b0; model_reset(); model_en = 1'b1;
    @(negedge clk);
    chk("rr_after_reset", 64'(grant), 64'b01);

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 4000; c++) begin
      step();
      req = N'($urandom);
      for (int e = 0; e < N; e++) eaddr[27*e +: 27] = 27'($urandom);
      for (int j = 0; j < 8*N; j++) edata[32*j +: 32] = $urandom;
      flush = ($urandom_range(0, 15) == 0);
      bus.biu_lsu_vb_grant  = ($urandom_range(0, 2) == 0);
      bus.biu_lsu_vb_wready = ($urandom_range(0, 3) != 0);
      bus.biu_lsu_vb_cmplt  = ($urandom_range(0, 3) == 0);
`ifdef PA_LSU_VB_WB_ERR_EN
      bus.biu_lsu_vb_err    = ($urandom_range(0, 7) == 0);
`endif
    end
    step();
    model_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pa_lsu_vb_wb_ctrl.md
Name: pa_lsu_vb_wb_ctrl

Overview:
Victim-buffer write-back controller, directly downstream of the VB entries.
- Arbitrates round-robin among entry write-back requests (entries in VB_WB).
- Grants one entry and issues its 256-bit dirty line to the BIU as a 4-beat 64-bit write burst.
- Returns a completion pulse to that entry when the bus write response arrives, so the entry can leave VB_WFC.

Parameters:
ENTRY_NUM, 2, number of VB entries served (1..4)

Ports:
forever_cpuclk  input  1  clock
cpurst  input  1  asynchronous reset, active-high
rtu_yy_xx_async_flush  input  1  pipeline flush
vb_entry_biu_req  input  ENTRY_NUM  per-entry write-back request (entry in VB_WB)
vb_entry_addr  input  27*ENTRY_NUM  per-entry line address [31:5], entry i at [27i+26:27i]
vb_entry_data  input  256*ENTRY_NUM  per-entry line data, entry i at [256i+255:256i]
vb_wb_grant  output  ENTRY_NUM  one-hot grant pulse to an entry
vb_wb_cmplt  output  ENTRY_NUM  one-hot completion pulse to an entry
lsu_biu_vb_req  output  1  bus address request
lsu_biu_vb_addr  output  32  burst address, {line_addr,5'b0}
biu_lsu_vb_grant  input  1  bus accepted address
lsu_biu_vb_wvld  output  1  write data beat valid
lsu_biu_vb_wdata  output  64  write data beat
lsu_biu_vb_wlast  output  1  final beat marker
biu_lsu_vb_wready  input  1  bus accepts beat
biu_lsu_vb_cmplt  input  1  bus write response
vb_wb_dbginfo  output  2  current FSM state

Behaviour:
FSM states: IDLE=00, REQ=01, DATA=10, RESP=11.

Reset (cpurst high, async):
- State IDLE; RR pointer 0; beat counter 0; entry index 0; flush-kill flag 0.
- All outputs 0.

IDLE:
- If any vb_entry_biu_req bit is set, pick the first requester at or after the RR pointer (wrap modulo ENTRY_NUM).
- Drive vb_wb_grant[sel]=1 combinationally, that cycle only.
- Latch sel, its address and its 256-bit data.
- RR pointer <= sel+1 mod ENTRY_NUM. Next state REQ.
- The entry's request drops next cycle (entry moves to VB_WFC); the controller must not rely on it after the grant.

REQ:
- lsu_biu_vb_req=1 with latched address.
- On biu_lsu_vb_grant: go to DATA, beat counter 0.

DATA:
- lsu_biu_vb_wvld=1; wdata = latched data[64k+63:64k], k = beat counter.
- wlast=1 when k==3.
- On wready: k increments; if k==3, go to RESP.
- wvld is continuous; no bubbles between beats.

RESP:
- Wait for biu_lsu_vb_cmplt.
- On cmplt: vb_wb_cmplt[idx]=1 for one cycle (combinational, same cycle), unless the kill flag is set. Go to IDLE, clear kill flag.
- A new arbitration starts the next cycle, never in the same cycle as cmplt.

Flush (rtu_yy_xx_async_flush):
- In IDLE: no grant is issued that cycle.
- In REQ before bus grant: return to IDLE, no bus activity. If flush and biu_lsu_vb_grant coincide, grant wins: go to DATA, set the kill flag.
- In DATA or RESP: the burst must complete (bus protocol). The kill flag is set, and the vb_wb_cmplt pulse is suppressed because the entry has already been reset to VB_IDLE.

Other rules:
- Latched data is a snapshot; later entry data changes have no effect.
- Any bus input arriving outside its expected state is ignored.
- Exactly one transaction is outstanding at a time.

Optional Feature:
Macro PA_LSU_VB_WB_ERR_EN.
- Defined:
  - Adds input biu_lsu_vb_err (1), sampled with biu_lsu_vb_cmplt.
  - Adds output vb_wb_err_sticky (1). It sets on cmplt&err, clears only on reset, and its reset value is 0.
  - vb_wb_cmplt is still pulsed on an error, so the entry always retires.
- Undefined: neither port exists and bus error status is discarded.

Test Plan:
1. Entry0 req, addr 27'h12345, data beats D0..D3 = 64'h0..3 → vb_wb_grant=2'b01 in the IDLE cycle; lsu_biu_vb_addr=32'h02468A0; beats 0,1,2,3 in order, wlast on beat 3; cmplt → vb_wb_cmplt=2'b01 for one cycle; state back to 00.
2. Both entries request continuously, ENTRY_NUM=2 → grant order entry0, entry1, entry0; no grant in the cmplt cycle.
3. wready deasserted for 2 cycles on beat 1 → wdata holds beat-1 data and wvld stays 1; total DATA time is 6 cycles.
4. Flush in REQ before bus grant → IDLE next cycle; no wvld and no vb_wb_cmplt.
5. Flush during DATA beat 2 → beats 2 and 3 still sent; cmplt received; vb_wb_cmplt stays 0.
6. cpurst asserted in DATA → all outputs 0 immediately (async), state 00, RR pointer 0. With PA_LSU_VB_WB_ERR_EN: cmplt with err=1 → vb_wb_err_sticky=1 and vb_wb_cmplt pulses.
